// File: rtl/mem_arbiter.sv
// Three-way memory port arbiter: debug always wins, fetch and load/store alternate
// round-robin. One access in flight at a time; an access with no mem_ready is aborted after TIMEOUT cycles.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic              ls_req,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic              ls_we,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              if_ack,
    output logic              ls_ack,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [1:0]        grant_id
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_IF   = 2'd1;
    localparam logic [1:0] GRANT_LS   = 2'd2;
    localparam logic [1:0] GRANT_DBG  = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              lastLs_q, lastLs_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
    logic              memEn_q, memEn_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ifAck_q, ifAck_d;
    logic              lsAck_q, lsAck_d;
    logic              dbgAck_q, dbgAck_d;
    logic              busy_q, busy_d;
    logic [1:0]        winner;
    logic              accessDone;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_NONE;
            lastLs_q   <= 1'b1;
            waitCnt_q  <= '0;
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            ifAck_q    <= 1'b0;
            lsAck_q    <= 1'b0;
            dbgAck_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            lastLs_q   <= lastLs_d;
            waitCnt_q  <= waitCnt_d;
            memEn_q    <= memEn_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ifAck_q    <= ifAck_d;
            lsAck_q    <= lsAck_d;
            dbgAck_q   <= dbgAck_d;
            busy_q     <= busy_d;
        end
    end

    // Every output is computed here one cycle ahead, so the ports come straight from flops.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        lastLs_d   = lastLs_q;
        waitCnt_d  = waitCnt_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rdata_d    = rdata_q;
        memEn_d    = 1'b0;
        err_d      = 1'b0;
        ifAck_d    = 1'b0;
        lsAck_d    = 1'b0;
        dbgAck_d   = 1'b0;
        winner     = GRANT_NONE;
        accessDone = 1'b0;

        case (state_q)
            IDLE: begin
                if (dbg_req)
                    winner = GRANT_DBG;
                else if (if_req && ls_req)
                    winner = lastLs_q ? GRANT_IF : GRANT_LS;
                else if (if_req)
                    winner = GRANT_IF;
                else if (ls_req)
                    winner = GRANT_LS;

                if (winner != GRANT_NONE) begin
                    state_d = ACCESS;
                    grant_d = winner;
                    memEn_d = 1'b1;
                    case (winner)
                        GRANT_IF: begin
                            memAddr_d  = if_addr;
                            memWe_d    = 1'b0;
                            memWdata_d = '0;
                            lastLs_d   = 1'b0;
                        end
                        GRANT_LS: begin
                            memAddr_d  = ls_addr;
                            memWe_d    = ls_we;
                            memWdata_d = ls_wdata;
                            lastLs_d   = 1'b1;
                        end
                        default: begin
                            memAddr_d  = dbg_addr;
                            memWe_d    = dbg_we;
                            memWdata_d = dbg_wdata;
                        end
                    endcase
                end
            end

            // The wait counter holds the number of completed stalled cycles of this access.
            ACCESS: begin
                if (mem_ready) begin
                    accessDone = 1'b1;
                    if (!memWe_q)
                        rdata_d = mem_rdata;
                end else if (waitCnt_q == LAST_WAIT) begin
                    accessDone = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    memEn_d   = 1'b1;
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end

                if (accessDone) begin
                    state_d  = RESP;
                    ifAck_d  = (grant_q == GRANT_IF);
                    lsAck_d  = (grant_q == GRANT_LS);
                    dbgAck_d = (grant_q == GRANT_DBG);
                end
            end

            RESP: begin
                state_d   = IDLE;
                grant_d   = GRANT_NONE;
                waitCnt_d = '0;
            end

            default: begin
                state_d   = IDLE;
                grant_d   = GRANT_NONE;
                waitCnt_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign if_ack    = ifAck_q;
    assign ls_ack    = lsAck_q;
    assign dbg_ack   = dbgAck_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_en    = memEn_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level reference model tracked every cycle,
// directed scenarios with literal expectations, then randomized traffic with reset pulses.
module tb_mem_arbiter;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ifReq = 1'b0, lsReq = 1'b0, dbgReq = 1'b0;
    logic [ADDR_W-1:0] ifAddr = '0, lsAddr = '0, dbgAddr = '0;
    logic              lsWe = 1'b0, dbgWe = 1'b0;
    logic [DATA_W-1:0] lsWdata = '0, dbgWdata = '0;
    logic [DATA_W-1:0] memRdata = '0;
    logic              memReady = 1'b0;

    logic              ifAck, lsAck, dbgAck, err, memEn, memWe, busy;
    logic [DATA_W-1:0] rdata, memWdata;
    logic [ADDR_W-1:0] memAddr;
    logic [1:0]        grantId;

    int testsRun  = 0;
    int failCount = 0;
    bit checkEnable = 1'b0;

    // Reference model: who owns the port, how long it has waited, whether it is answering.
    int                mOwner;
    int                mAge;
    int                mLastRR;
    bit                mDone;
    bit                mTimedOut;
    bit                mWe;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mWdata;
    logic [DATA_W-1:0] mRdata;

    int         grants[8];
    int         nGrants;
    logic [1:0] prevGrant;
    int         readyPct;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (ifReq),
        .ls_req    (lsReq),
        .dbg_req   (dbgReq),
        .if_addr   (ifAddr),
        .ls_addr   (lsAddr),
        .dbg_addr  (dbgAddr),
        .ls_we     (lsWe),
        .dbg_we    (dbgWe),
        .ls_wdata  (lsWdata),
        .dbg_wdata (dbgWdata),
        .if_ack    (ifAck),
        .ls_ack    (lsAck),
        .dbg_ack   (dbgAck),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (memEn),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_rdata (memRdata),
        .mem_ready (memReady),
        .busy      (busy),
        .grant_id  (grantId)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        mOwner    = 0;
        mAge      = 0;
        mLastRR   = 2;
        mDone     = 1'b0;
        mTimedOut = 1'b0;
        mWe       = 1'b0;
        mAddr     = '0;
        mWdata    = '0;
        mRdata    = '0;
    endtask

    task automatic modelStep();
        int winner;
        winner = 0;
        if (mOwner == 0) begin
            if (dbgReq)
                winner = 3;
            else if (ifReq && lsReq)
                winner = (mLastRR == 1) ? 2 : 1;
            else if (ifReq)
                winner = 1;
            else if (lsReq)
                winner = 2;
            if (winner != 0) begin
                mOwner    = winner;
                mAge      = 1;
                mDone     = 1'b0;
                mTimedOut = 1'b0;
                if (winner != 3)
                    mLastRR = winner;
                if (winner == 1) begin
                    mAddr = ifAddr; mWe = 1'b0; mWdata = '0;
                end else if (winner == 2) begin
                    mAddr = lsAddr; mWe = lsWe; mWdata = lsWdata;
                end else begin
                    mAddr = dbgAddr; mWe = dbgWe; mWdata = dbgWdata;
                end
            end
        end else if (!mDone) begin
            if (memReady) begin
                mDone = 1'b1;
                if (!mWe)
                    mRdata = memRdata;
            end else if (mAge == TIMEOUT) begin
                mDone     = 1'b1;
                mTimedOut = 1'b1;
            end else begin
                mAge++;
            end
        end else begin
            mOwner    = 0;
            mAge      = 0;
            mDone     = 1'b0;
            mTimedOut = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset)
                modelReset();
            else
                modelStep();
        end
    end

    task automatic compareAll();
        checkOutput("mem_en",    32'(memEn),    32'(mOwner != 0 && !mDone));
        checkOutput("mem_we",    32'(memWe),    32'(mWe));
        checkOutput("mem_addr",  32'(memAddr),  32'(mAddr));
        checkOutput("mem_wdata", memWdata,      mWdata);
        checkOutput("rdata",     rdata,         mRdata);
        checkOutput("err",       32'(err),      32'(mDone && mTimedOut));
        checkOutput("if_ack",    32'(ifAck),    32'(mDone && mOwner == 1));
        checkOutput("ls_ack",    32'(lsAck),    32'(mDone && mOwner == 2));
        checkOutput("dbg_ack",   32'(dbgAck),   32'(mDone && mOwner == 3));
        checkOutput("busy",      32'(busy),     32'(mOwner != 0));
        checkOutput("grant_id",  32'(grantId),  32'(mOwner));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (checkEnable)
                compareAll();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic recordGrant();
        if (grantId != 2'd0 && prevGrant == 2'd0 && nGrants < 8) begin
            grants[nGrants] = int'(grantId);
            nGrants++;
        end
        prevGrant = grantId;
    endtask

    // Requesters hold until acked, drop right after the ack edge, and sometimes give up before being granted.
    task automatic applyStimulus();
        if (mDone && mOwner == 1)
            ifReq = 1'b0;
        else if (!ifReq)
            ifReq = ($urandom_range(0, 99) < 30);
        else if (mOwner != 1 && $urandom_range(0, 15) == 0)
            ifReq = 1'b0;

        if (mDone && mOwner == 2)
            lsReq = 1'b0;
        else if (!lsReq)
            lsReq = ($urandom_range(0, 99) < 30);
        else if (mOwner != 2 && $urandom_range(0, 15) == 0)
            lsReq = 1'b0;

        if (mDone && mOwner == 3)
            dbgReq = 1'b0;
        else if (!dbgReq)
            dbgReq = ($urandom_range(0, 99) < 8);
        else if (mOwner != 3 && $urandom_range(0, 15) == 0)
            dbgReq = 1'b0;

        ifAddr   = ADDR_W'($urandom);
        lsAddr   = ADDR_W'($urandom);
        dbgAddr  = ADDR_W'($urandom);
        lsWe     = 1'($urandom_range(0, 1));
        dbgWe    = 1'($urandom_range(0, 1));
        lsWdata  = $urandom;
        dbgWdata = $urandom;
        memRdata = $urandom;
        memReady = ($urandom_range(0, 99) < readyPct);
    endtask

    initial begin
        int enCount;
        int resetHold;

        foreach (grants[i]) grants[i] = 0;
        nGrants   = 0;
        prevGrant = 2'd0;
        readyPct  = 80;
        resetHold = 0;

        #1;
        reset = 1'b0;
        checkEnable = 1'b1;

        // V1: requests toggling while reset is held low
        for (int i = 0; i < 6; i++) begin
            ifReq  = 1'($urandom_range(0, 1));
            lsReq  = 1'($urandom_range(0, 1));
            dbgReq = 1'($urandom_range(0, 1));
            step();
            checkOutput("v1_mem_en",   32'(memEn), 32'd0);
            checkOutput("v1_grant_id", 32'(grantId), 32'd0);
            checkOutput("v1_acks",     32'(ifAck | lsAck | dbgAck), 32'd0);
        end
        ifReq = 1'b0; lsReq = 1'b0; dbgReq = 1'b0;
        reset = 1'b1;

        // V2: fetch read
        ifReq = 1'b1; ifAddr = 16'h0005; memReady = 1'b1; memRdata = 32'hDEADBEEF;
        step();
        checkOutput("v2_mem_en",   32'(memEn), 32'd1);
        checkOutput("v2_mem_addr", 32'(memAddr), 32'h0005);
        checkOutput("v2_grant_id", 32'(grantId), 32'd1);
        step();
        checkOutput("v2_if_ack",   32'(ifAck), 32'd1);
        checkOutput("v2_rdata",    rdata, 32'hDEADBEEF);
        checkOutput("v2_err",      32'(err), 32'd0);
        checkOutput("v2_mem_en_off", 32'(memEn), 32'd0);
        ifReq = 1'b0;
        step();
        checkOutput("v2_if_ack_off", 32'(ifAck), 32'd0);
        checkOutput("v2_busy_off",   32'(busy), 32'd0);

        // V3: load/store write leaves rdata alone
        lsReq = 1'b1; lsAddr = 16'd25; lsWe = 1'b1; lsWdata = 32'h00000004; memRdata = 32'h12345678;
        step();
        checkOutput("v3_mem_we",    32'(memWe), 32'd1);
        checkOutput("v3_mem_addr",  32'(memAddr), 32'd25);
        checkOutput("v3_mem_wdata", memWdata, 32'd4);
        step();
        checkOutput("v3_ls_ack", 32'(lsAck), 32'd1);
        checkOutput("v3_rdata",  rdata, 32'hDEADBEEF);
        lsReq = 1'b0; lsWe = 1'b0;
        step();
        checkOutput("v3_ls_ack_off", 32'(lsAck), 32'd0);

        // V4: fetch and load/store both held
        memRdata = 32'hA5A50000; ifReq = 1'b1; lsReq = 1'b1; ifAddr = 16'h0100; lsAddr = 16'h0200;
        nGrants = 0; prevGrant = 2'd0;
        for (int i = 0; i < 12; i++) begin
            step();
            recordGrant();
            checkOutput("v4_two_acks", 32'(ifAck & lsAck), 32'd0);
        end
        ifReq = 1'b0; lsReq = 1'b0;
        checkOutput("v4_grant_count", 32'(nGrants), 32'd4);
        checkOutput("v4_grant0", 32'(grants[0]), 32'd1);
        checkOutput("v4_grant1", 32'(grants[1]), 32'd2);
        checkOutput("v4_grant2", 32'(grants[2]), 32'd1);
        checkOutput("v4_grant3", 32'(grants[3]), 32'd2);

        // V5: all three together; debug must not disturb the fetch/load-store rotation
        dbgReq = 1'b1; ifReq = 1'b1; lsReq = 1'b1; dbgAddr = 16'h0300; dbgWe = 1'b0;
        nGrants = 0; prevGrant = 2'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            recordGrant();
            if (mDone && mOwner == 3) dbgReq = 1'b0;
            if (mDone && mOwner == 1) ifReq = 1'b0;
            if (mDone && mOwner == 2) lsReq = 1'b0;
        end
        checkOutput("v5_grant_count", 32'(nGrants), 32'd3);
        checkOutput("v5_grant0", 32'(grants[0]), 32'd3);
        checkOutput("v5_grant1", 32'(grants[1]), 32'd1);
        checkOutput("v5_grant2", 32'(grants[2]), 32'd2);

        // V6: memory never ready, then a reset in the third access cycle
        memReady = 1'b0; memRdata = 32'h11111111; ifReq = 1'b1; ifAddr = 16'h0042;
        enCount = 0;
        step();
        while (memEn === 1'b1 && enCount < 20) begin
            enCount++;
            step();
        end
        checkOutput("v6_en_cycles", 32'(enCount), 32'(TIMEOUT));
        checkOutput("v6_if_ack",    32'(ifAck), 32'd1);
        checkOutput("v6_err",       32'(err), 32'd1);
        checkOutput("v6_rdata",     rdata, 32'hA5A50000);
        ifReq = 1'b0;
        step();
        checkOutput("v6_err_off", 32'(err), 32'd0);
        checkOutput("v6_busy_off", 32'(busy), 32'd0);

        ifReq = 1'b1;
        repeat (3) step();
        checkOutput("v6_mem_en_before_reset", 32'(memEn), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("v6_abort_mem_en",   32'(memEn), 32'd0);
        checkOutput("v6_abort_busy",     32'(busy), 32'd0);
        checkOutput("v6_abort_grant_id", 32'(grantId), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("v6_abort_no_ack", 32'(ifAck | lsAck | dbgAck), 32'd0);
        end
        ifReq = 1'b0;
        reset = 1'b1;
        step();
        checkOutput("v6_after_reset_busy", 32'(busy), 32'd0);

        // Randomized traffic, alternating fast and slow memory, with occasional reset pulses
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (cyc % 250 == 0)
                readyPct = (readyPct == 80) ? 8 : 80;
            if (resetHold > 0) begin
                resetHold--;
                if (resetHold == 0)
                    reset = 1'b1;
            end else if (cyc % 700 == 350) begin
                reset = 1'b0;
                resetHold = 2;
            end
            applyStimulus();
        end

        reset = 1'b1;
        ifReq = 1'b0; lsReq = 1'b0; dbgReq = 1'b0;
        memReady = 1'b1;
        repeat (4) step();
        checkOutput("final_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
